// File: rtl/otter_iobus_periph.sv
// otter_iobus_periph: memory-mapped IOBUS responder for the OTTER CPU.
// A 16-byte register window holds four word registers:
//   offset 0 LEDS (RW), 1 SWITCHES (RO), 2 TXDATA (WO), 3 STATUS/CTRL (RW).
// TXDATA writes fill a byte FIFO that drains over a TX_VALID/TX_READY
// handshake. An optional one-cycle interrupt fires when the drain finishes.
module otter_iobus_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    input  logic [15:0] SWITCHES,
    output logic [15:0] LEDS,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        INTR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OFF_LEDS = 2'd0;
    localparam logic [1:0] OFF_SW   = 2'd1;
    localparam logic [1:0] OFF_TX   = 2'd2;
    localparam logic [1:0] OFF_STAT = 2'd3;

    // Address decode
    logic       hit;
    logic [1:0] off;
    logic       wr_leds;
    logic       wr_tx;
    logic       wr_stat;

    // FIFO storage and control
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          overflow;
    logic          irq_en;

    // Switch synchronizer stages
    logic [15:0] sw_p0;
    logic [15:0] sw_p1;

    // Byte-lane address bits and the upper write-data half are not decoded.
    logic unused_bits;
    assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT[31:16]};

    // Packs the STATUS word; everything outside the named fields reads 0.
    function automatic logic [31:0] pack_status(
        input logic       is_empty,
        input logic       is_full,
        input logic       ovf,
        input logic       irq,
        input logic [4:0] cnt
    );
        return {19'b0, cnt, 4'b0, irq, ovf, is_full, is_empty};
    endfunction

    assign hit     = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign off     = IOBUS_ADDR[3:2];
    assign wr_leds = IOBUS_WR && hit && (off == OFF_LEDS);
    assign wr_tx   = IOBUS_WR && hit && (off == OFF_TX);
    assign wr_stat = IOBUS_WR && hit && (off == OFF_STAT);

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = !empty && TX_READY;
    // A push into a full FIFO is still accepted when the head leaves on the same edge.
    assign push     = wr_tx && (!full || pop);
    assign TX_VALID = !empty;
    assign TX_DATA  = mem[rd_ptr];

    // Occupancy after this edge: push and pop together leave it unchanged.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Read-data mux: combinational from the presented address; misses read 0.
    always_comb begin
        IOBUS_IN = 32'h0;
        if (hit) begin
            case (off)
                OFF_LEDS: IOBUS_IN = {16'h0, LEDS};
                OFF_SW:   IOBUS_IN = {16'h0, sw_p1};
                OFF_TX:   IOBUS_IN = 32'h0;
                OFF_STAT: IOBUS_IN = pack_status(empty, full, overflow, irq_en, 5'(count));
                default:  IOBUS_IN = 32'h0;
            endcase
        end
    end

    // ---- stage boundary: two-flop switch synchronizer ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_p0 <= '0;
            sw_p1 <= '0;
        end else begin
            sw_p0 <= SWITCHES;
            sw_p1 <= sw_p0;
        end
    end

    // LED register: loads the low half-word on a hitting write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LEDS <= '0;
        end else if (wr_leds) begin
            LEDS <= IOBUS_OUT[15:0];
        end
    end

    // FIFO storage: data only, contents are meaningless after reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= IOBUS_OUT[7:0];
        end
    end

    // FIFO pointers and occupancy; power-of-two depth gives natural wrap.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // Sticky overflow and interrupt enable; overflow only when a byte is really lost.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (wr_tx && full && !pop) begin
                overflow <= 1'b1;
            end else if (wr_stat && IOBUS_OUT[2]) begin
                overflow <= 1'b0;
            end
            if (wr_stat) begin
                irq_en <= IOBUS_OUT[3];
            end
        end
    end

    // Drain-complete pulse: last byte popped with no refill on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            INTR <= 1'b0;
        end else begin
            INTR <= irq_en && pop && !push && (count == CW'(1));
        end
    end

endmodule

// File: doc/otter_iobus_periph.md
OTTER_IOBUS_PERIPH -- requirements
Module: otter_iobus_periph

Memory-mapped IOBUS responder for the OTTER CPU. It decodes CPU IOBUS accesses, holds an LED register, synchronizes switches, and drains a byte TX FIFO over a valid/ready handshake.

Interface
REQ-001 Parameter BASE_ADDR, 32'h1100_0000, base of the 16-byte register window; bits [3:0] SHALL be zero.
REQ-002 Parameter DEPTH, 8, TX FIFO entries; SHALL be a power of two, 2..16.
REQ-003 Port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port RESET  input  1  synchronous, active-high reset.
REQ-005 Port IOBUS_ADDR  input  32  CPU byte address.
REQ-006 Port IOBUS_OUT  input  32  CPU write data.
REQ-007 Port IOBUS_WR  input  1  CPU write strobe, one cycle per store.
REQ-008 Port IOBUS_IN  output  32  read data returned to the CPU.
REQ-009 Port SWITCHES  input  16  asynchronous board switches.
REQ-010 Port LEDS  output  16  LED register.
REQ-011 Port TX_DATA  output  8  FIFO head byte.
REQ-012 Port TX_VALID  output  1  FIFO non-empty.
REQ-013 Port TX_READY  input  1  consumer accepts TX_DATA.
REQ-014 Port INTR  output  1  drain-complete interrupt pulse to the CPU.

Function
REQ-015 Hit SHALL be IOBUS_ADDR[31:4]==BASE_ADDR[31:4]; register offset = IOBUS_ADDR[3:2]; IOBUS_ADDR[1:0] ignored.
REQ-016 Offsets: 0 LEDS (RW), 1 SWITCHES (RO), 2 TXDATA (WO, reads 0), 3 STATUS/CTRL (RW).
REQ-017 IOBUS_IN SHALL be combinational from IOBUS_ADDR and current state, valid in the same cycle the address is presented; a miss or unmapped field reads 0.
REQ-018 A write SHALL take effect at the edge where IOBUS_WR=1 and hit=1; writes that miss are ignored.
REQ-019 LEDS write loads IOBUS_OUT[15:0]; the new value is visible on LEDS and on readback the cycle after the write edge.
REQ-020 SWITCHES pass through a two-flop synchronizer; a read returns the second stage zero-extended; input-to-readable latency is 2 edges.
REQ-021 TXDATA write pushes IOBUS_OUT[7:0] if not full; if full, the byte is dropped and sticky overflow is set.
REQ-022 STATUS read fields:
  - bit0 empty
  - bit1 full
  - bit2 overflow
  - bit3 irq_en
  - bits[12:8] count (0..DEPTH)
  - all other bits 0
REQ-023 STATUS write: IOBUS_OUT[2]=1 clears overflow (0 leaves it unchanged); irq_en <= IOBUS_OUT[3]; other bits ignored.
REQ-024 TX_VALID SHALL equal !empty; TX_DATA SHALL equal the head entry and hold stable while TX_VALID=1 and TX_READY=0.
REQ-025 Pop occurs at an edge with TX_VALID=1 and TX_READY=1; the read pointer advances modulo DEPTH.
REQ-026 Write pointer advances modulo DEPTH on an accepted push; count = pushes - pops; full = count==DEPTH, empty = count==0.
REQ-027 Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
REQ-028 Push while empty: no bypass; TX_VALID rises the cycle after the push edge.
REQ-029 INTR SHALL be registered and high for exactly one cycle following an edge where count goes 1->0 by pop while irq_en=1; it is otherwise 0.
REQ-030 An edge with both a pop of the last entry and a push SHALL leave count at 1 and SHALL NOT raise INTR.

Reset
REQ-031 On RESET=1 at an edge, the following SHALL clear:
  - LEDS=0, INTR=0, TX_VALID=0
  - count and both pointers=0
  - overflow=0, irq_en=0
  - both synchronizer stages=0
REQ-032 RESET SHALL override any same-cycle write or pop; FIFO contents are discarded; TX_DATA is don't-care while TX_VALID=0.

Verification
REQ-033 Write 0x1100_0000 data 0x0000_A5A5 -> LEDS=0xA5A5 next cycle; read offset 0 returns 0x0000_A5A5; write to 0x1200_0000 leaves LEDS unchanged.
REQ-034 SWITCHES=0x1234 -> offset-1 read returns 0 before 2 edges have elapsed and 0x0000_1234 from the 2nd edge on.
REQ-035 TX_READY=0; push 9 bytes 0x01..0x09 with DEPTH=8 -> STATUS=0x0000_0806 (count 8, full, overflow); then TX_READY=1 -> TX_DATA 0x01..0x08 in order, byte 0x09 never appears.
REQ-036 FIFO full, push and pop in the same cycle -> count stays 8, overflow stays 0; next head is the second-oldest byte.
REQ-037 irq_en=1, one byte queued, TX_READY=1 -> INTR=1 for exactly one cycle after the pop; with irq_en=0, INTR stays 0.
REQ-038 Three bytes queued, overflow set, LEDS=0xFFFF; assert RESET for one cycle concurrent with a TXDATA write -> TX_VALID=0, STATUS=0x0000_0001, LEDS=0.
